// File: rtl/px_stream_buf.sv
// rtl/px_stream_buf.sv - SD-to-LCD word FIFO with paced read strobes and block-boundary pulse.
// Optional STREAM_BYTE_SWAP_EN: byte-swap each halfword on the read path (LE to RGB565 BE).
module px_stream_buf #(
  parameter int DEPTH         = 16,
  parameter int WORDS_PER_BLK = 128
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic [31:0]              in_data,
  input  logic                     in_trigger,
  output logic                     in_busy,
  output logic [31:0]              out_data,
  output logic                     out_trigger,
  input  logic                     out_busy,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     blk_done,
  output logic                     overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int CW = $clog2(WORDS_PER_BLK + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [31:0]     r_mem [DEPTH];
  logic [PW-1:0]   r_wr_ptr;
  logic [PW-1:0]   r_rd_ptr;
  logic [CW-1:0]   r_word_cnt;
  logic            r_overflow;
  logic [31:0]     r_out_data;
  logic            w_full;
  logic            w_empty;
  logic            w_wr_en;
  logic            w_last_word;
  logic [31:0]     w_mem_word;
  logic [31:0]     w_rd_word;

  // Extra pointer MSB distinguishes full from empty when the address bits match.
  assign w_full  = (r_wr_ptr[PW-1] != r_rd_ptr[PW-1]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_wr_en = in_trigger && !w_full && !flush;

  assign w_mem_word = r_mem[r_rd_ptr[AW-1:0]];
`ifdef STREAM_BYTE_SWAP_EN
  assign w_rd_word = {w_mem_word[23:16], w_mem_word[31:24], w_mem_word[7:0], w_mem_word[15:8]};
`else
  assign w_rd_word = w_mem_word;
`endif

  assign w_last_word = (r_word_cnt == CW'(WORDS_PER_BLK - 1));

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (!w_empty && !out_busy) w_state_nxt = S_ISSUE;
      S_ISSUE: w_state_nxt = S_GAP;
      S_GAP:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_wr_en) r_mem[r_wr_ptr[AW-1:0]] <= in_data;
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_state    <= S_IDLE;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_word_cnt <= '0;
      r_overflow <= 1'b0;
      r_out_data <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_wr_en) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (in_trigger && w_full) r_overflow <= 1'b1;
      // Output word is registered on entry to ISSUE so it is stable for the whole strobe.
      if (r_state == S_IDLE && w_state_nxt == S_ISSUE) r_out_data <= w_rd_word;
      if (r_state == S_ISSUE) begin
        r_rd_ptr   <= r_rd_ptr + PW'(1);
        r_word_cnt <= w_last_word ? '0 : r_word_cnt + CW'(1);
      end
    end
  end

  assign in_busy     = w_full;
  assign out_trigger = (r_state == S_ISSUE);
  assign out_data    = r_out_data;
  assign blk_done    = (r_state == S_ISSUE) && w_last_word;
  assign level       = r_wr_ptr - r_rd_ptr;
  assign overflow    = r_overflow;

endmodule

// File: tb/tb_px_stream_buf.sv
// tb/tb_px_stream_buf.sv - randomized and directed bench for px_stream_buf against a queue model.
module tb_px_stream_buf;
  localparam int DEPTH = 16;
  localparam int WPB   = 128;

  logic        clk = 1'b0;
  logic        rst, flush, in_trigger, out_busy;
  logic [31:0] in_data;
  logic        in_busy, out_trigger, blk_done, overflow;
  logic [31:0] out_data;
  logic [4:0]  level;

  always #5 clk = ~clk;

  px_stream_buf #(.DEPTH(DEPTH), .WORDS_PER_BLK(WPB)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_data(in_data), .in_trigger(in_trigger), .in_busy(in_busy),
    .out_data(out_data), .out_trigger(out_trigger), .out_busy(out_busy),
    .level(level), .blk_done(blk_done), .overflow(overflow)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] rd_view(input logic [31:0] w);
`ifdef STREAM_BYTE_SWAP_EN
    return {w[23:16], w[31:24], w[7:0], w[15:8]};
`else
    return w;
`endif
  endfunction

  // Model: contents as a queue, strobes allowed when a word was waiting, the consumer
  // was idle the cycle before, and at least 3 cycles have passed since the previous strobe.
  logic [31:0] mq[$];
  bit          m_ovf;
  int          m_cnt;
  int          m_last;
  bit          m_trig;
  logic [31:0] m_data;
  int          cyc = 0;
  bit          m_started = 0;

  task automatic model_step();
    bit          nt;
    bit          full;
    logic [31:0] nd;
    if (rst || flush) begin
      mq.delete();
      m_ovf = 0; m_cnt = 0; m_last = -100; m_trig = 0; m_data = '0;
    end else begin
      if (m_trig) m_last = cyc;
      full = (mq.size() == DEPTH);
      nt = (mq.size() != 0) && !out_busy && (cyc + 1 - m_last >= 3);
      nd = m_data;
      if (nt) nd = rd_view(mq[0]);
      if (m_trig) begin
        void'(mq.pop_front());
        m_cnt++;
      end
      if (in_trigger) begin
        if (!full) mq.push_back(in_data);
        else m_ovf = 1;
      end
      m_trig = nt;
      m_data = nd;
    end
    cyc++;
    m_started = 1;
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    if (m_started) begin
      chk("out_trigger", out_trigger, m_trig);
      if (m_trig) begin
        chk("out_data", out_data, m_data);
        chk("blk_done", blk_done, (m_cnt % WPB) == WPB - 1);
      end else begin
        chk("blk_done_idle", blk_done, 0);
      end
      chk("level", level, mq.size());
      chk("in_busy", in_busy, mq.size() == DEPTH);
      chk("overflow", overflow, m_ovf);
    end
  end

  int s_trig;
  int s_blk[$];

  task automatic stream(input int n);
    int sent = 0;
    s_trig = 0;
    s_blk.delete();
    for (int c = 0; c < 20000 && s_trig < n; c++) begin
      in_trigger = (sent < n) && !in_busy && ($urandom % 4 != 0);
      in_data    = $urandom;
      if (in_trigger) sent++;
      out_busy = ($urandom % 6 == 0);
      @(negedge clk);
      if (out_trigger) begin
        s_trig++;
        if (blk_done) s_blk.push_back(s_trig);
      end
    end
    in_trigger = 0;
    out_busy   = 0;
  endtask

  task automatic do_flush();
    flush = 1;
    @(negedge clk);
    flush = 0;
  endtask

  initial begin
    int first_j;
    int prev_j;
    int n;
    rst = 1; flush = 0; in_trigger = 0; out_busy = 0; in_data = '0;
    repeat (3) @(negedge clk);
    chk("rst_level", level, 0);
    chk("rst_in_busy", in_busy, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_out_trigger", out_trigger, 0);
    chk("rst_out_data", out_data, 0);
    rst = 0;

    // single word latency
    in_data = 32'hA1B2C3D4; in_trigger = 1;
    @(negedge clk);
    in_trigger = 0;
    chk("t1_no_early_trig", out_trigger, 0);
    @(negedge clk);
    chk("t1_trig", out_trigger, 1);
`ifdef STREAM_BYTE_SWAP_EN
    chk("t1_data", out_data, 32'hB2A1D4C3);
`else
    chk("t1_data", out_data, 32'hA1B2C3D4);
`endif
    @(negedge clk);
    chk("t1_level", level, 0);

    // fill while consumer busy, then one dropped write
    repeat (2) @(negedge clk);
    out_busy = 1;
    for (int i = 0; i < 17; i++) begin
      in_data = 32'h1000 + i; in_trigger = 1;
      @(negedge clk);
    end
    in_trigger = 0;
    chk("t2_level", level, 16);
    chk("t2_in_busy", in_busy, 1);
    chk("t2_overflow", overflow, 1);

    // drain from full: pulses every 3 cycles in order
    out_busy = 0;
    n = 0; first_j = -1; prev_j = -1;
    for (int j = 1; j <= 60; j++) begin
      @(negedge clk);
      if (j == first_j + 1 && first_j > 0) chk("t3_in_busy_drop", in_busy, 0);
      if (out_trigger) begin
        chk("t3_order", out_data, rd_view(32'h1000 + n));
        if (prev_j > 0) chk("t3_spacing", j - prev_j, 3);
        if (first_j < 0) first_j = j;
        prev_j = j;
        n++;
      end
    end
    chk("t3_first_at", first_j, 1);
    chk("t3_count", n, 16);

    // 256-word continuous stream
    do_flush();
    stream(256);
    chk("t4_count", s_trig, 256);
    chk("t4_nblk", s_blk.size(), 2);
    if (s_blk.size() == 2) begin
      chk("t4_blk0", s_blk[0], 128);
      chk("t4_blk1", s_blk[1], 256);
    end
    chk("t4_overflow", overflow, 0);

    // flush mid-block discards words and the partial count
    do_flush();
    stream(40);
    out_busy = 1;
    for (int i = 0; i < 5; i++) begin
      in_data = $urandom; in_trigger = 1;
      @(negedge clk);
    end
    in_trigger = 0;
    chk("t5_level5", level, 5);
    do_flush();
    chk("t5_level0", level, 0);
    chk("t5_no_trig", out_trigger, 0);
    out_busy = 0;
    @(negedge clk);
    chk("t5_no_trig2", out_trigger, 0);
    stream(128);
    chk("t5_nblk", s_blk.size(), 1);
    if (s_blk.size() == 1) chk("t5_blk0", s_blk[0], 128);

    // simultaneous write and read at DEPTH-1
    do_flush();
    out_busy = 1;
    for (int i = 0; i < DEPTH - 1; i++) begin
      in_data = 32'h2000 + i; in_trigger = 1;
      @(negedge clk);
    end
    in_trigger = 0;
    chk("t6_level_pre", level, DEPTH - 1);
    out_busy = 0;
    @(negedge clk);
    chk("t6_trig", out_trigger, 1);
    in_trigger = 1; in_data = 32'h2FFF; out_busy = 1;
    @(negedge clk);
    in_trigger = 0;
    chk("t6_level", level, DEPTH - 1);
    chk("t6_in_busy", in_busy, 0);

    // randomized traffic with occasional flush, reset and blind writes
    do_flush();
    for (int c = 0; c < 4000; c++) begin
      out_busy   = ($urandom % 3 == 0);
      in_trigger = (!in_busy && ($urandom % 2 == 1)) || ($urandom % 32 == 0);
      in_data    = $urandom;
      flush      = ($urandom % 300 == 0);
      rst        = ($urandom % 900 == 0);
      @(negedge clk);
    end
    rst = 0; flush = 0; in_trigger = 0; out_busy = 0;
    repeat (60) @(negedge clk);
    chk("end_level", level, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
